regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file; successor to the single-write/dual-read CPU register file.

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: one write port, NRD read ports, clear request and ready flag.
// Master side is the pipeline (decode/writeback); slave side is the register file.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int NRD    = 2
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic                  clr_req;
   logic                  ready;
   logic                  we;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;

   modport master (
      output clr_req, we, wr_addr, wr_data, rd_addr,
      input  ready, rd_data
   );

   modport slave (
      input  clr_req, we, wr_addr, wr_data, rd_addr,
      output ready, rd_data
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware clear sweep (DEPTH cycles after reset or clr_req).
// Reads are registered, 1-cycle latency; no backpressure, ready=0 while sweeping (writes ignored).
// Define REGFILE_BYPASS_EN for write-first forwarding on same-edge write/read; default is read-first.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave rf
);
   localparam int                ADDR_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic [NRD*DATA_W-1:0] rd_q, rd_d;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdat;
   logic                  wr_ok;
   logic [ADDR_W-1:0]     ra;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // A write only lands when live, in range and not aimed at the hardwired zero.
   assign wr_ok = (state_q == READY) && rf.we && in_range(rf.wr_addr) && !is_zero(rf.wr_addr);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      mem_we   = 1'b0;
      mem_addr = rf.wr_addr;
      mem_wdat = rf.wr_data;
      case (state_q)
         CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_wdat = '0;
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               state_d = READY;
               ready_d = 1'b1;
            end
         end
         READY: begin
            mem_we = wr_ok;
            if (rf.clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               ready_d = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      rd_d = '0;
      ra   = '0;
      if (state_q == READY) begin
         for (int p = 0; p < NRD; p++) begin
            ra = rf.rd_addr[p*ADDR_W +: ADDR_W];
            if (in_range(ra) && !is_zero(ra)) begin
`ifdef REGFILE_BYPASS_EN
               if (wr_ok && (ra == rf.wr_addr))
                  rd_d[p*DATA_W +: DATA_W] = rf.wr_data;
               else
                  rd_d[p*DATA_W +: DATA_W] = mem[ra];
`else
               rd_d[p*DATA_W +: DATA_W] = mem[ra];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         rd_q    <= rd_d;
      end
   end

   // Storage is left alone during reset; the sweep that follows zeroes it.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we)
         mem[mem_addr] <= mem_wdat;
   end

   assign rf.ready   = ready_q;
   assign rf.rd_data = rd_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: DUT a (DEPTH 32, 2 ports, zero reg) and DUT b (DEPTH 24, 3 ports, r0 ordinary).
// Expected read data and ready are pushed per edge from a behavioural model and popped after the edge.
`timescale 1ns/1ps
module tb_regfile_mp;
   localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int          d;
      int          p;
      logic [31:0] exp;
   } sb_t;

   logic        clk;
   logic        rst_n;
   string       phase;
   int          n_cmp = 0;
   int          n_bad = 0;
   sb_t         sbq[$];
   int          dep[2]  = '{32, 24};
   bit          zr[2]   = '{1'b1, 1'b0};
   int          left[2] = '{32, 24};
   logic [31:0] mm [2][32];

   regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NRD(2)) ifa ();
   regfile_mp_if #(.DATA_W(32), .DEPTH(24), .NRD(3)) ifb ();

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (ifa)
   );

   regfile_mp #(.DATA_W(32), .DEPTH(24), .NRD(3), .ZERO_REG(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Predict what DUT d shows after the coming edge, then advance the model.
   task automatic expect_edge(input int d);
      logic              we, clr, wok;
      logic [AW-1:0]     wa, ra;
      logic [31:0]       wd, e;
      int                np;
      if (d == 0) begin
         we = ifa.we; wa = ifa.wr_addr; wd = ifa.wr_data; clr = ifa.clr_req; np = 2;
      end else begin
         we = ifb.we; wa = ifb.wr_addr; wd = ifb.wr_data; clr = ifb.clr_req; np = 3;
      end
      wok = (left[d] == 0) && we && (int'(wa) < dep[d]) && !(zr[d] && wa == '0);
      for (int p = 0; p < np; p++) begin
         if (d == 0) ra = ifa.rd_addr[p*AW +: AW];
         else        ra = ifb.rd_addr[p*AW +: AW];
         if (!rst_n || left[d] != 0 || int'(ra) >= dep[d] || (zr[d] && ra == '0))
            e = '0;
         else if (BYP && wok && ra == wa)
            e = wd;
         else
            e = mm[d][ra];
         sbq.push_back('{d, p, e});
      end
      if (!rst_n) begin
         left[d] = dep[d];
      end else if (left[d] != 0) begin
         left[d]--;
         if (left[d] == 0)
            for (int i = 0; i < 32; i++) mm[d][i] = '0;
      end else begin
         if (wok) mm[d][wa] = wd;
         if (clr) left[d] = dep[d];
      end
      sbq.push_back('{d, -1, {31'b0, left[d] == 0}});
   endtask

   task automatic tick();
      sb_t         s;
      logic [31:0] got;
      string       tag;
      expect_edge(0);
      expect_edge(1);
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         if (s.d == 0) got = (s.p < 0) ? {31'b0, ifa.ready} : ifa.rd_data[s.p*32 +: 32];
         else          got = (s.p < 0) ? {31'b0, ifb.ready} : ifb.rd_data[s.p*32 +: 32];
         tag = (s.p < 0) ? $sformatf("%s.%s.ready", phase, s.d == 0 ? "a" : "b")
                         : $sformatf("%s.%s.rd%0d", phase, s.d == 0 ? "a" : "b", s.p);
         check(tag, got, s.exp);
      end
   endtask

   task automatic idle();
      ifa.we = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = '0; ifa.clr_req = 1'b0;
      ifb.we = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = '0; ifb.clr_req = 1'b0;
   endtask

   task automatic wr_a(input logic [AW-1:0] a, input logic [31:0] v);
      ifa.we = 1'b1; ifa.wr_addr = a; ifa.wr_data = v;
      tick();
      ifa.we = 1'b0;
   endtask

   task automatic wr_b(input logic [AW-1:0] a, input logic [31:0] v);
      ifb.we = 1'b1; ifb.wr_addr = a; ifb.wr_data = v;
      tick();
      ifb.we = 1'b0;
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i += 2) begin
         ifa.rd_addr = {AW'(i + 1), AW'(i)};
         ifb.rd_addr = {AW'((i + 2) % 24), AW'((i + 1) % 24), AW'(i % 24)};
         tick();
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;

      phase = "T1";
      tick();
      tick();
      rst_n = 1'b1;
      repeat (32) tick();
      read_all();

      phase = "T2";
      ifb.we = 1'b1; ifb.wr_addr = 5'd0; ifb.wr_data = 32'hCAFE0000;
      wr_a(5'd5, 32'hDEADBEEF);
      ifb.we = 1'b0;
      wr_a(5'd0, 32'h12345678);
      ifa.rd_addr = {5'd0, 5'd5};
      ifb.rd_addr = {5'd5, 5'd0, 5'd0};
      tick();

      phase = "T3";
      wr_a(5'd7, 32'h11111111);
      ifa.rd_addr = {5'd3, 5'd7};
      wr_a(5'd7, 32'hA5A5A5A5);
      tick();
      ifb.rd_addr = {5'd9, 5'd9, 5'd9};
      wr_b(5'd9, 32'h99999999);
      tick();

      phase = "T4";
      for (int i = 1; i < 32; i++) wr_a(AW'(i), 32'(i));
      read_all();
      ifa.clr_req = 1'b1;
      ifa.rd_addr = {5'd4, 5'd3};
      wr_a(5'd3, 32'h55);
      ifa.clr_req = 1'b0;
      ifa.we = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h55;
      repeat (4) tick();
      ifa.we = 1'b0;
      repeat (28) tick();
      read_all();

      phase = "T5";
      wr_a(5'd9, 32'h0BADF00D);
      ifa.clr_req = 1'b1;
      tick();
      ifa.clr_req = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ifa.we = 1'b1; ifa.wr_addr = 5'd9; ifa.wr_data = 32'h99;
      ifb.we = 1'b1; ifb.wr_addr = 5'd9; ifb.wr_data = 32'h77;
      repeat (32) tick();
      idle();
      read_all();

      phase = "T6";
      wr_b(5'd23, 32'h23232323);
      wr_b(5'd30, 32'h00000BAD);
      ifb.rd_addr = {5'd30, 5'd23, 5'd30};
      ifb.we = 1'b1; ifb.wr_addr = 5'd30; ifb.wr_data = 32'hFFFFFFFF;
      tick();
      ifb.we = 1'b0;
      read_all();

      phase = "RND";
      for (int n = 0; n < 300; n++) begin
         ifa.we      = 1'($urandom);
         ifa.wr_addr = AW'($urandom);
         ifa.wr_data = $urandom;
         ifa.rd_addr = {AW'($urandom), AW'($urandom)};
         ifa.clr_req = ($urandom_range(0, 63) == 0);
         ifb.we      = 1'($urandom);
         ifb.wr_addr = AW'($urandom);
         ifb.wr_data = $urandom;
         ifb.rd_addr = {AW'($urandom), AW'($urandom), AW'($urandom)};
         ifb.clr_req = ($urandom_range(0, 63) == 0);
         tick();
      end
      idle();
      repeat (32) tick();
      read_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
